// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute/write-back controller for a 16x16 register file and external ALU
//
// Purpose:
//   Multi-cycle sequencer. It fetches 16-bit instructions, addresses the
//   register file, hands the operands to an external ALU over a start/done
//   handshake and writes the result back.
//   Instruction word: [15:12] class, [11:8] rd/rs1, [7:4] rs2, [3:0] func.
//   Class F = ALU op, 0 = NOP, E = HALT, anything else = illegal (err + HALT).
//
// Ports:
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_run                        level enable, sampled in IDLE and at instruction boundaries
//   o_imem_req/o_imem_addr       fetch request (held until valid) and fetch address (= pc)
//   i_imem_valid/i_imem_data     instruction word return
//   o_rf_raddr1/2, i_rf_rdata1/2 register file read port (1-cycle registered read)
//   o_alu_start/o_alu_opcode     ALU start pulse and function
//   o_alu_a/o_alu_b              ALU operands, held from start until done
//   i_alu_done/i_alu_result      ALU completion and result
//   o_rf_we/o_rf_waddr/o_rf_wdata register file write port (single-cycle strobe)
//   o_busy                       not in IDLE or HALT
//   o_halted                     in HALT
//   o_err                        sticky: illegal instruction or ALU timeout
//
// Optional feature (macro SEQ_PERF_CNT_EN):
//   o_retired_cnt [15:0]         saturating count of retired ALU ops and NOPs
module instr_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_valid,
  input  logic [15:0]       i_imem_data,
  output logic [3:0]        o_rf_raddr1,
  output logic [3:0]        o_rf_raddr2,
  input  logic [15:0]       i_rf_rdata1,
  input  logic [15:0]       i_rf_rdata2,
  output logic              o_alu_start,
  output logic [3:0]        o_alu_opcode,
  output logic [15:0]       o_alu_a,
  output logic [15:0]       o_alu_b,
  input  logic              i_alu_done,
  input  logic [15:0]       i_alu_result,
  output logic              o_rf_we,
  output logic [3:0]        o_rf_waddr,
  output logic [15:0]       o_rf_wdata,
`ifdef SEQ_PERF_CNT_EN
  output logic [15:0]       o_retired_cnt,
`endif
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_err
);

  localparam logic [3:0] CLASS_ALU  = 4'hF;
  localparam logic [3:0] CLASS_NOP  = 4'h0;
  localparam logic [3:0] CLASS_HALT = 4'hE;

  // Counts EXEC cycles; value 0 is the start cycle.
  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [15:0]         r_instr;
  logic [15:0]         r_alu_a;
  logic [15:0]         r_alu_b;
  logic [15:0]         r_wdata;
  logic                r_err;
  logic [CNT_W-1:0]    r_exec_cnt;

  logic [3:0]          w_class;
  logic [3:0]          w_rd;
  logic [3:0]          w_rs2;
  logic [3:0]          w_func;
  logic                w_exec_first;
  logic                w_pc_inc;
  logic                w_set_err;
  logic                w_capture_instr;
  logic                w_capture_result;
  logic                w_imem_req;
  logic                w_alu_start;
  logic                w_rf_we;

  assign w_class      = r_instr[15:12];
  assign w_rd         = r_instr[11:8];
  assign w_rs2        = r_instr[7:4];
  assign w_func       = r_instr[3:0];
  assign w_exec_first = (r_exec_cnt == '0);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_next_state     = r_state;
    w_pc_inc         = 1'b0;
    w_set_err        = 1'b0;
    w_capture_instr  = 1'b0;
    w_capture_result = 1'b0;
    w_imem_req       = 1'b0;
    w_alu_start      = 1'b0;
    w_rf_we          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_next_state = S_FETCH;
        end
      end

      S_FETCH: begin
        w_imem_req = 1'b1;
        if (i_imem_valid) begin
          w_capture_instr = 1'b1;
          w_next_state    = S_DECODE;
        end
      end

      S_DECODE: begin
        case (w_class)
          CLASS_ALU: begin
            w_next_state = S_READ;
          end
          CLASS_NOP: begin
            w_pc_inc     = 1'b1;
            w_next_state = i_run ? S_FETCH : S_IDLE;
          end
          CLASS_HALT: begin
            w_next_state = S_HALT;
          end
          default: begin
            w_set_err    = 1'b1;
            w_next_state = S_HALT;
          end
        endcase
      end

      S_READ: begin
        w_next_state = S_EXEC;
      end

      S_EXEC: begin
        // done is not looked at in the start cycle, so a stale done
        // from the ALU cannot complete the new operation.
        if (w_exec_first) begin
          w_alu_start = 1'b1;
        end else if (i_alu_done) begin
          w_capture_result = 1'b1;
          w_next_state     = S_WB;
        end else if (r_exec_cnt == CNT_W'(ALU_TIMEOUT - 1)) begin
          // Enter HALT exactly ALU_TIMEOUT cycles after the start cycle.
          w_set_err    = 1'b1;
          w_next_state = S_HALT;
        end
      end

      S_WB: begin
        w_rf_we      = (w_rd != 4'd0);
        w_pc_inc     = 1'b1;
        w_next_state = i_run ? S_FETCH : S_IDLE;
      end

      S_HALT: begin
        w_next_state = S_HALT;
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc       <= '0;
      r_instr    <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_exec_cnt <= '0;
    end else begin
      if (w_capture_instr) begin
        r_instr <= i_imem_data;
      end
      // Read addresses were presented in DECODE; the file's registered
      // data is valid during READ.
      if (r_state == S_READ) begin
        r_alu_a <= i_rf_rdata1;
        r_alu_b <= i_rf_rdata2;
      end
      if (w_capture_result) begin
        r_wdata <= i_alu_result;
      end
      if (w_pc_inc) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (r_state == S_EXEC) begin
        r_exec_cnt <= r_exec_cnt + CNT_W'(1);
      end else begin
        r_exec_cnt <= '0;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic        w_retire;
  logic [15:0] r_retired_cnt;

  assign w_retire = (r_state == S_WB) ||
                    ((r_state == S_DECODE) && (w_class == CLASS_NOP));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_retired_cnt <= '0;
    end else if (w_retire && (r_retired_cnt != 16'hFFFF)) begin
      r_retired_cnt <= r_retired_cnt + 16'd1;
    end
  end

  assign o_retired_cnt = r_retired_cnt;
`endif

  assign o_imem_req   = w_imem_req;
  assign o_imem_addr  = r_pc;
  assign o_rf_raddr1  = w_rd;
  assign o_rf_raddr2  = w_rs2;
  assign o_alu_start  = w_alu_start;
  assign o_alu_opcode = w_func;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_rf_we      = w_rf_we;
  assign o_rf_waddr   = w_rd;
  assign o_rf_wdata   = r_wdata;
  assign o_busy       = (r_state != S_IDLE) && (r_state != S_HALT);
  assign o_halted     = (r_state == S_HALT);
  assign o_err        = r_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;

  localparam int ADDR_W      = 8;
  localparam int ALU_TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              run = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [15:0]       imem_data;
  logic [3:0]        rf_raddr1, rf_raddr2;
  logic [15:0]       rf_rdata1, rf_rdata2;
  logic              alu_start;
  logic [3:0]        alu_opcode;
  logic [15:0]       alu_a, alu_b;
  logic              alu_done;
  logic [15:0]       alu_result;
  logic              rf_we;
  logic [3:0]        rf_waddr;
  logic [15:0]       rf_wdata;
  logic              busy, halted, err;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0]       retired_cnt;
`endif

  always #5 clk = ~clk;

  instr_sequencer #(.ADDR_W(ADDR_W), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_run        (run),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_valid (imem_valid),
    .i_imem_data  (imem_data),
    .o_rf_raddr1  (rf_raddr1),
    .o_rf_raddr2  (rf_raddr2),
    .i_rf_rdata1  (rf_rdata1),
    .i_rf_rdata2  (rf_rdata2),
    .o_alu_start  (alu_start),
    .o_alu_opcode (alu_opcode),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .i_alu_done   (alu_done),
    .i_alu_result (alu_result),
    .o_rf_we      (rf_we),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata),
`ifdef SEQ_PERF_CNT_EN
    .o_retired_cnt(retired_cnt),
`endif
    .o_busy       (busy),
    .o_halted     (halted),
    .o_err        (err)
  );

  // Instruction memory: answers in the same cycle as the request.
  logic [15:0] imem [256];
  assign imem_valid = imem_req;
  assign imem_data  = imem[imem_addr];

  // Register file with registered read; the bench preloads via pre_*.
  logic [15:0] rf [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = 4'd0;
  logic [15:0] pre_data = 16'd0;
  always @(posedge clk) begin
    rf_rdata1 <= rf[rf_raddr1];
    rf_rdata2 <= rf[rf_raddr2];
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  // ALU: done alu_delay cycles after start (0 = never); result a+b.
  int   alu_delay = 1;
  int   alu_cnt = 0;
  logic manual_done = 1'b0;
  always @(posedge clk) begin
    if (alu_start) alu_cnt <= alu_delay;
    else if (alu_cnt > 0) alu_cnt <= alu_cnt - 1;
  end
  assign alu_done   = (alu_cnt == 1) | manual_done;
  assign alu_result = alu_a + alu_b;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected register writes {addr, data}.
  logic [19:0] exp_q[$];
  int n_we = 0;
  int n_start = 0;
  always @(negedge clk) begin
    if (alu_start) n_start++;
    if (rf_we) begin
      n_we++;
      check("sb_write_expected", 96'(exp_q.size() > 0), 96'd1);
      if (exp_q.size() > 0) check("sb_write", {rf_waddr, rf_wdata}, exp_q.pop_front());
    end
  end

  function automatic logic [77:0] all_outs();
    return {imem_req, imem_addr, rf_raddr1, rf_raddr2, alu_start, alu_opcode,
            alu_a, alu_b, rf_we, rf_waddr, rf_wdata, busy, halted, err};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_reset(input logic run_after);
    @(negedge clk);
    reset = 1'b1; run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; run = run_after;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check(tag, 96'(imem_req), 96'd1);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (alu_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check(tag, 96'(alu_start), 96'd1);
  endtask

  task automatic wait_halt(input int bound, output int n);
    n = 0;
    while (halted !== 1'b1 && n < bound) begin @(negedge clk); n++; end
  endtask

  int n, we0, st0;

  initial begin
    clear_imem();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 96'(all_outs()), 96'd0);

    // Type A: F120, R1=0F00, R2=0050, ALU done one cycle after start
    imem[0] = 16'hF120;
    imem[1] = 16'hE000;
    alu_delay = 1;
    preload(4'd1, 16'h0F00);
    preload(4'd2, 16'h0050);
    exp_q.push_back({4'd1, 16'h0F50});
    we0 = n_we; st0 = n_start;
    do_reset(1'b1);
    wait_req("t1_fetch");
    check("t1_fetch_addr", 96'(imem_addr), 96'd0);
    n = 1;
    while (rf_we !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("t1_wb_cycle", 96'(n), 96'd6);
    @(negedge clk);
    check("t1_next_fetch", {imem_req, imem_addr}, {1'b1, 8'd1});
    wait_halt(10, n);
    check("t1_halt_err", {halted, err, busy}, {1'b1, 1'b0, 1'b0});
    check("t1_one_write", 96'(n_we - we0), 96'd1);
    check("t1_one_start", 96'(n_start - st0), 96'd1);

    // NOP then HALT
    clear_imem();
    imem[1] = 16'hE000;
    we0 = n_we;
    do_reset(1'b1);
    wait_req("t2_fetch");
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr == 8'd1) && n < 20) begin @(negedge clk); n++; end
    check("t2_nop_cycles", 96'(n), 96'd2);
    wait_halt(10, n);
    check("t2_halt_state", {halted, err, busy}, {1'b1, 1'b0, 1'b0});
    check("t2_no_write", 96'(n_we - we0), 96'd0);

    // Illegal class
    clear_imem();
    imem[0] = 16'h3000;
    st0 = n_start;
    do_reset(1'b1);
    wait_req("t3_fetch");
    wait_halt(10, n);
    check("t3_halt_cycle", 96'(n), 96'd2);
    check("t3_halt_err", {halted, err, busy}, {1'b1, 1'b1, 1'b0});
    check("t3_no_start", 96'(n_start - st0), 96'd0);

    // ALU timeout
    clear_imem();
    imem[0] = 16'hF120;
    alu_delay = 0;
    we0 = n_we; st0 = n_start;
    do_reset(1'b1);
    wait_start("t4_start");
    wait_halt(40, n);
    check("t4_timeout_cycle", 96'(n), 96'(ALU_TIMEOUT));
    check("t4_halt_err", {halted, err}, {1'b1, 1'b1});
    check("t4_one_start", 96'(n_start - st0), 96'd1);
    check("t4_no_write", 96'(n_we - we0), 96'd0);

    // rd=0 suppression, then slower ALU (done 3 cycles after start)
    clear_imem();
    imem[0] = 16'hF020;
    imem[1] = 16'hF120;
    imem[2] = 16'hE000;
    alu_delay = 3;
    preload(4'd0, 16'h0007);
    preload(4'd1, 16'h1234);
    preload(4'd2, 16'h0101);
    exp_q.push_back({4'd1, 16'h1335});
    we0 = n_we; st0 = n_start;
    do_reset(1'b1);
    wait_halt(60, n);
    check("t5_halted", {halted, err}, {1'b1, 1'b0});
    check("t5_writes", 96'(n_we - we0), 96'd1);
    check("t5_starts", 96'(n_start - st0), 96'd2);

    // pc wrap through 256 NOPs
    clear_imem();
    do_reset(1'b1);
    wait_req("t6_fetch");
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(imem_req === 1'b1 && imem_addr == 8'd0) && n < 600);
    check("t6_wrap_cycles", 96'(n), 96'd512);
    check("t6_wrap_addr", {imem_req, imem_addr}, {1'b1, 8'd0});
`ifdef SEQ_PERF_CNT_EN
    check("t6_retired", 96'(retired_cnt), 96'd256);
`endif
    run = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    check("t6_idle", {busy, halted}, {1'b0, 1'b0});

    // Reset during EXEC, then a late done
    clear_imem();
    imem[0] = 16'hF120;
    alu_delay = 0;
    preload(4'd1, 16'h00A0);
    preload(4'd2, 16'h000B);
    we0 = n_we;
    do_reset(1'b1);
    wait_start("t7_start");
    @(negedge clk);
    check("t7_in_exec", {busy, alu_a, alu_b}, {1'b1, 16'h00A0, 16'h000B});
    reset = 1'b1; run = 1'b0;
    @(negedge clk);
    check("t7_reset_outputs", 96'(all_outs()), 96'd0);
    reset = 1'b0;
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    check("t7_idle", {imem_req, busy, rf_we}, {1'b0, 1'b0, 1'b0});
    @(negedge clk);
    check("t7_no_write", 96'(n_we - we0), 96'd0);
    run = 1'b1;
    @(negedge clk);
    check("t7_refetch", {imem_req, imem_addr}, {1'b1, 8'd0});
    run = 1'b0;

    check("sb_empty", 96'(exp_q.size()), 96'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
